// File: rtl/async_fifo_rd_ctrl.sv
// rtl/async_fifo_rd_ctrl.sv - read-domain controller for the async FIFO
//
// Purpose:
//   Brings the Gray write pointer into rclk through a two-flop synchronizer.
//   Keeps the binary and Gray read pointers and drives the memory read
//   address. Derives empty and a fill level from them, and registers the
//   memory's combinational read data into a first-word-fall-through output
//   stage that uses a valid/ready handshake.
//
// Ports:
//   rclk          read-domain clock, rising edge
//   rrst          synchronous active-high reset
//   g_wptr_async  Gray write pointer from the wclk domain (unsynchronized)
//   mem_rdata     combinational memory data at address b_rptr[PTR_WIDTH-1:0]
//   b_rptr        registered binary read pointer; low bits address the memory
//   g_rptr        registered Gray read pointer, sent to the write domain
//   empty         memory holds no unread entry
//   dout          output data register
//   dout_valid    dout holds a valid word
//   dout_ready    consumer accepts dout this cycle
//   rd_level      entries available to the consumer (memory + output stage)

module async_fifo_rd_ctrl #(
   parameter int FIFO_WIDTH = 8,
   parameter int PTR_WIDTH  = 3
) (
   input  logic                  rclk,
   input  logic                  rrst,
   input  logic [PTR_WIDTH:0]    g_wptr_async,
   input  logic [FIFO_WIDTH-1:0] mem_rdata,
   output logic [PTR_WIDTH:0]    b_rptr,
   output logic [PTR_WIDTH:0]    g_rptr,
   output logic                  empty,
   output logic [FIFO_WIDTH-1:0] dout,
   output logic                  dout_valid,
   input  logic                  dout_ready,
   output logic [PTR_WIDTH+1:0]  rd_level
);

   // Synchronizer stages
   logic [PTR_WIDTH:0]    sync1_q, sync1_d;
   logic [PTR_WIDTH:0]    g_wptr_sync_q, g_wptr_sync_d;

   // Read pointers and output stage
   logic [PTR_WIDTH:0]    b_rptr_q, b_rptr_d;
   logic [PTR_WIDTH:0]    g_rptr_q, g_rptr_d;
   logic [FIFO_WIDTH-1:0] dout_q, dout_d;
   logic                  dout_valid_q, dout_valid_d;

   logic                  pop;
   logic [PTR_WIDTH:0]    b_next;
   logic [PTR_WIDTH:0]    wbin;
   logic [PTR_WIDTH:0]    mem_lvl;

   function automatic logic [PTR_WIDTH:0] gray_to_bin(input logic [PTR_WIDTH:0] g);
      logic [PTR_WIDTH:0] b;
      b[PTR_WIDTH] = g[PTR_WIDTH];
      for (int i = PTR_WIDTH - 1; i >= 0; i--) begin
         b[i] = b[i+1] ^ g[i];
      end
      return b;
   endfunction

   always_ff @(posedge rclk) begin
      if (rrst) begin
         sync1_q       <= '0;
         g_wptr_sync_q <= '0;
         b_rptr_q      <= '0;
         g_rptr_q      <= '0;
         dout_q        <= '0;
         dout_valid_q  <= 1'b0;
      end else begin
         sync1_q       <= sync1_d;
         g_wptr_sync_q <= g_wptr_sync_d;
         b_rptr_q      <= b_rptr_d;
         g_rptr_q      <= g_rptr_d;
         dout_q        <= dout_d;
         dout_valid_q  <= dout_valid_d;
      end
   end

   always_comb begin
      // The raw cross-domain pointer feeds only the first sync flop.
      sync1_d       = g_wptr_async;
      g_wptr_sync_d = sync1_q;

      empty  = (g_rptr_q == g_wptr_sync_q);
      // Refill the output stage whenever it is empty or being drained this cycle.
      pop    = !empty && (!dout_valid_q || dout_ready);
      b_next = b_rptr_q + 1'b1;

      b_rptr_d     = b_rptr_q;
      g_rptr_d     = g_rptr_q;
      dout_d       = dout_q;
      dout_valid_d = dout_valid_q;

      if (pop) begin
         b_rptr_d     = b_next;
         g_rptr_d     = (b_next >> 1) ^ b_next;
         dout_d       = mem_rdata;
         dout_valid_d = 1'b1;
      end else if (dout_valid_q && dout_ready) begin
         dout_valid_d = 1'b0;
      end

      // Modulo subtraction works across the lap bit, giving 0..DEPTH.
      wbin     = gray_to_bin(g_wptr_sync_q);
      mem_lvl  = wbin - b_rptr_q;
      rd_level = {1'b0, mem_lvl} + {{(PTR_WIDTH+1){1'b0}}, dout_valid_q};
   end

   assign b_rptr     = b_rptr_q;
   assign g_rptr     = g_rptr_q;
   assign dout       = dout_q;
   assign dout_valid = dout_valid_q;

endmodule

// File: tb/tb_async_fifo_rd_ctrl.sv
// tb/tb_async_fifo_rd_ctrl.sv - randomized self-checking bench for async_fifo_rd_ctrl

module tb_async_fifo_rd_ctrl;

   logic       rclk;
   logic       rrst;
   logic [3:0] g_wptr_async;
   logic [7:0] mem_rdata;
   logic [3:0] b_rptr;
   logic [3:0] g_rptr;
   logic       empty;
   logic [7:0] dout;
   logic       dout_valid;
   logic       dout_ready;
   logic [4:0] rd_level;

   async_fifo_rd_ctrl #(.FIFO_WIDTH(8), .PTR_WIDTH(3)) dut (
      .rclk         (rclk),
      .rrst         (rrst),
      .g_wptr_async (g_wptr_async),
      .mem_rdata    (mem_rdata),
      .b_rptr       (b_rptr),
      .g_rptr       (g_rptr),
      .empty        (empty),
      .dout         (dout),
      .dout_valid   (dout_valid),
      .dout_ready   (dout_ready),
      .rd_level     (rd_level)
   );

   initial rclk = 1'b0;
   always #5 rclk = ~rclk;

   // Bench-owned memory, read combinationally at the DUT's address.
   logic [7:0] mem [8];
   assign mem_rdata = mem[b_rptr[2:0]];

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model: plain counts of entries written, synchronized, and read.
   int         wr_cnt;
   int         s1_cnt, s2_cnt;
   int         rd_cnt;
   int         exp_dv;
   int         exp_dout;
   logic [7:0] data_hist[$];

   function automatic int gray(input int v);
      int b;
      b = v % 16;
      return b ^ (b >> 1);
   endfunction

   task automatic check_eq(input string tag, input int got, input int exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic check_all();
      check_eq("b_rptr",     int'(b_rptr),     rd_cnt % 16);
      check_eq("g_rptr",     int'(g_rptr),     gray(rd_cnt));
      check_eq("empty",      int'(empty),      (rd_cnt == s2_cnt) ? 1 : 0);
      check_eq("dout",       int'(dout),       exp_dout);
      check_eq("dout_valid", int'(dout_valid), exp_dv);
      check_eq("rd_level",   int'(rd_level),   s2_cnt - rd_cnt + exp_dv);
   endtask

   // Apply inputs after a falling edge, advance the model one rclk edge,
   // then compare at the next falling edge.
   task automatic step(input bit rdy, input bit wr, input bit rst);
      bit         pop;
      logic [7:0] d;
      dout_ready = rdy;
      rrst       = rst;
      if (rst) begin
         wr_cnt       = 0;
         g_wptr_async = 4'b0000;
         data_hist.delete();
      end else if (wr && (wr_cnt - rd_cnt) < 8) begin
         d = 8'($urandom);
         mem[wr_cnt % 8] = d;
         data_hist.push_back(d);
         wr_cnt++;
         g_wptr_async = 4'(gray(wr_cnt));
      end
      if (rst) begin
         s1_cnt = 0; s2_cnt = 0; rd_cnt = 0; exp_dv = 0; exp_dout = 0;
      end else begin
         pop = (rd_cnt != s2_cnt) && (exp_dv == 0 || rdy);
         if (pop) begin
            exp_dout = int'(data_hist[rd_cnt]);
            exp_dv   = 1;
            rd_cnt++;
         end else if (exp_dv == 1 && rdy) begin
            exp_dv = 0;
         end
         s2_cnt = s1_cnt;
         s1_cnt = wr_cnt;
      end
      @(posedge rclk);
      @(negedge rclk);
      check_all();
   endtask

   initial begin
      rrst         = 1'b1;
      dout_ready   = 1'b0;
      g_wptr_async = 4'b0000;
      for (int i = 0; i < 8; i++) mem[i] = 8'h00;
      wr_cnt = 0; s1_cnt = 0; s2_cnt = 0; rd_cnt = 0; exp_dv = 0; exp_dout = 0;
      @(negedge rclk);

      // Reset held for two cycles.
      step(1'b0, 1'b0, 1'b1);
      step(1'b0, 1'b0, 1'b1);
      check_eq("rst_level", int'(rd_level), 0);

      // Single word with a known value, held under backpressure.
      dout_ready = 1'b0;
      rrst       = 1'b0;
      mem[0]     = 8'hA5;
      data_hist.push_back(8'hA5);
      wr_cnt       = 1;
      g_wptr_async = 4'b0001;
      s2_cnt = s1_cnt; s1_cnt = wr_cnt;
      @(posedge rclk); @(negedge rclk);
      check_all();
      step(1'b0, 1'b0, 1'b0);
      check_eq("sw_empty", int'(empty), 0);
      check_eq("sw_level", int'(rd_level), 1);
      step(1'b0, 1'b0, 1'b0);
      check_eq("sw_dout", int'(dout), 8'hA5);
      check_eq("sw_grptr", int'(g_rptr), 1);
      for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b0);
      check_eq("sw_hold", int'(dout), 8'hA5);

      // Randomized phases: streaming, heavy backpressure, mixed.
      for (int ph = 0; ph < 3; ph++) begin
         for (int c = 0; c < 200; c++) begin
            bit rdy, wr;
            case (ph)
               0: begin rdy = 1'b1; wr = ($urandom_range(0, 7) != 0); end
               1: begin rdy = ($urandom_range(0, 3) == 0); wr = ($urandom_range(0, 1) == 0); end
               default: begin rdy = ($urandom_range(0, 1) == 0); wr = ($urandom_range(0, 2) != 0); end
            endcase
            step(rdy, wr, 1'b0);
         end
      end

      // Drain, then build up dout_valid=1 with rd_level=4 and reset mid-stream.
      for (int c = 0; c < 12; c++) step(1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b0);
      for (int c = 0; c < 4; c++) step(1'b0, 1'b0, 1'b0);
      check_eq("pre_rst_dv", int'(dout_valid), 1);
      check_eq("pre_rst_level", int'(rd_level), 4);
      step(1'b0, 1'b0, 1'b1);
      check_eq("mid_rst_level", int'(rd_level), 0);
      for (int c = 0; c < 4; c++) step(1'b1, 1'b0, 1'b0);
      check_eq("post_rst_dv", int'(dout_valid), 0);
      for (int c = 0; c < 60; c++) step($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/async_fifo_rd_ctrl.md
Name: async_fifo_rd_ctrl

Overview:
- Read-domain controller for the async FIFO.
- Synchronizes the Gray write pointer into rclk and maintains the binary and Gray read pointers.
- Generates `empty` and a fill level, and drives the memory read address.
- Registers the memory's combinational read data into a first-word-fall-through output stage with a valid/ready handshake.

Parameters:
- FIFO_WIDTH, 8, data width in bits.
- PTR_WIDTH, 3, address bits; depth = 1<<PTR_WIDTH; pointers are PTR_WIDTH+1 bits.

Ports:
- rclk  input  1  read-domain clock; all logic on rising edge.
- rrst  input  1  synchronous, active-high reset.
- g_wptr_async  input  PTR_WIDTH+1  Gray write pointer from wclk domain, unsynchronized.
- mem_rdata  input  FIFO_WIDTH  combinational memory data at address b_rptr[PTR_WIDTH-1:0].
- b_rptr  output  PTR_WIDTH+1  binary read pointer (registered); low bits are the memory address.
- g_rptr  output  PTR_WIDTH+1  Gray read pointer (registered), sent to the write domain.
- empty  output  1  memory holds no unread entry.
- dout  output  FIFO_WIDTH  output data register.
- dout_valid  output  1  dout holds a valid word.
- dout_ready  input  1  consumer accepts dout this cycle.
- rd_level  output  PTR_WIDTH+2  entries available to the consumer (memory + output stage).

Behaviour:
- **Reset.** When rrst=1 at a rclk edge, the following clear:
  - sync stages to 0;
  - b_rptr=0, g_rptr=0, dout=0, dout_valid=0;
  - therefore empty=1 and rd_level=0.
  - Reset mid-operation discards dout and all unread data. The write side must be reset in the same window.
- **Synchronizer.**
  - Two-flop chain: sync1 <= g_wptr_async; g_wptr_sync <= sync1.
  - No other logic touches g_wptr_async.
- **Empty.**
  - empty = (g_rptr == g_wptr_sync), combinational from registers.
  - Reset value 1.
- **Pop.**
  - pop = !empty && (!dout_valid || dout_ready).
  - On pop:
    - dout <= mem_rdata;
    - dout_valid <= 1;
    - b_rptr <= b_rptr+1 (mod 2^(PTR_WIDTH+1));
    - g_rptr <= (b_next>>1)^b_next.
- **No pop.**
  - If dout_valid && dout_ready: dout_valid <= 0 and dout holds its value.
  - Otherwise everything holds.
- **Simultaneous accept and pop.** Back-to-back transfer: dout is replaced and dout_valid stays 1. Throughput is one word per cycle.
- **Backpressure.** With dout_valid=1 and dout_ready=0: no pop, and dout and dout_valid stay stable.
- **Latency.**
  - A stable change on g_wptr_async reaches g_wptr_sync after 2 rclk edges.
  - empty then deasserts combinationally.
  - dout_valid rises on the next edge, i.e. 3 edges after the change.
- **Wrap-around.**
  - b_rptr wraps from 2*DEPTH-1 to 0.
  - The memory address wraps DEPTH-1 to 0.
  - The MSB toggles each lap and distinguishes full from empty.
- **Level.**
  - wbin = Gray-to-binary(g_wptr_sync).
  - mem_lvl = (wbin - b_rptr) mod 2^(PTR_WIDTH+1), range 0..DEPTH.
  - rd_level = mem_lvl + dout_valid, zero-extended, maximum DEPTH+1.
  - rd_level is combinational.
- **Pointer integrity.**
  - g_rptr changes by exactly one bit per pop.
  - b_rptr never passes the synchronized write pointer.
  - empty blocks pop, so underflow is impossible.

Test Plan:
1. **Reset.** Assert rrst for 2 cycles, then deassert → b_rptr=0, g_rptr=0, empty=1, dout=0, dout_valid=0, rd_level=0.
2. **Single word.** PTR_WIDTH=3, dout_ready=0, mem_rdata=8'hA5; set g_wptr_async=4'b0001.
   - After 2 edges: empty=0, rd_level=1.
   - Next edge: dout=A5, dout_valid=1, b_rptr=1, g_rptr=0001, empty=1, rd_level=1.
   - Held for 5 cycles: outputs unchanged.
3. **Stream.** g_wptr_async=gray(8)=4'b1100, dout_ready=1, mem_rdata=address-based pattern → 8 consecutive pops, one per cycle, dout sequence 0..7.
   - Final state: b_rptr=8, g_rptr=1100, empty=1.
   - dout_valid falls one cycle after the last accept.
4. **Wrap.** Continue from scenario 3 by writing 8 more entries (g_wptr_async=gray(0)=0000) → b_rptr goes 15→0, g_rptr goes 1000→0000, address goes 7→0, no data skipped, empty=1 at the end.
5. **Backpressure.** 3 entries pending, dout_ready=0 for 5 cycles → exactly one pop; dout stable; rd_level=3 throughout.
   - Then dout_ready=1 → the remaining 2 entries follow on consecutive cycles.
6. **Reset mid-stream.** Assert rrst with dout_valid=1 and rd_level=4 → next edge: all outputs at reset values, no further pops until g_wptr_async advances after the write side is also reset.
